// File: rtl/s1neuron_backprop.sv
// Backward pass of the single-layer fixed-point neuron: one element per clock
// computes the updated weight and the back-propagated error, with saturation.
module s1neuron_backprop #(
  parameter int          M        = 8,
  parameter int          n        = 32,
  parameter int          intbits  = 12,
  parameter int          fracbits = 20,
  parameter logic [n-1:0] LR      = 32'h0000_1000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M*n-1:0] X,
  input  logic [M*n-1:0] W,
  input  logic [n-1:0]   delta,
  output logic           busy,
  output logic           done,
  output logic [M*n-1:0] W_new,
  output logic [M*n-1:0] err_out,
  output logic           ovf
);

  if (intbits + fracbits != n) begin : g_param_check
    $error("intbits + fracbits must equal n");
  end

  localparam int idx_w = (M > 1) ? $clog2(M) : 1;
  localparam logic [n-1:0] sat_max = {1'b0, {(n-1){1'b1}}};
  localparam logic [n-1:0] sat_min = {1'b1, {(n-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCALE, UPDATE, DONE} state_t;

  typedef struct packed {
    logic [n-1:0] val;
    logic         sat;
  } sat_t;

  // Q-format multiply: full product, floor shift, clamp to n bits.
  function automatic sat_t mul(input logic [n-1:0] a, input logic [n-1:0] b);
    logic signed [2*n-1:0] ae, be, prod, shifted;
    logic        [n:0]     hi;
    sat_t                  r;
    ae      = {{n{a[n-1]}}, a};
    be      = {{n{b[n-1]}}, b};
    prod    = ae * be;
    shifted = prod >>> fracbits;
    hi      = shifted[2*n-1:n-1];
    r.sat   = (hi != '0) && (hi != '1);
    if (r.sat) r.val = shifted[2*n-1] ? sat_min : sat_max;
    else       r.val = shifted[n-1:0];
    return r;
  endfunction

  function automatic sat_t sub(input logic [n-1:0] a, input logic [n-1:0] b);
    logic [n:0] d;
    sat_t       r;
    d     = {a[n-1], a} - {b[n-1], b};
    r.sat = d[n] ^ d[n-1];
    if (r.sat) r.val = d[n] ? sat_min : sat_max;
    else       r.val = d[n-1:0];
    return r;
  endfunction

  state_t             state, state_next;
  logic [idx_w-1:0]   index;
  logic               last;
  logic [M*n-1:0]     x_l, w_l;
  logic [n-1:0]       delta_l;
  logic [n-1:0]       step;
  logic [31:0]        base;
  sat_t               step_m, prod_m, w_sub, err_m;

  assign last = (index == idx_w'(M - 1));
  assign base = 32'(index) * 32'(n);

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = SCALE;
      end
      SCALE:  state_next = UPDATE;
      UPDATE: if (last) state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    step_m = mul(LR, delta_l);
    prod_m = mul(step, x_l[base +: n]);
    w_sub  = sub(w_l[base +: n], prod_m.val);
    err_m  = mul(delta_l, w_l[base +: n]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      W_new   <= '0;
      err_out <= '0;
      ovf     <= 1'b0;
      index   <= '0;
      step    <= '0;
    end else begin
      case (state)
        IDLE: if (start) ovf <= 1'b0;
        SCALE: begin
          step  <= step_m.val;
          ovf   <= ovf | step_m.sat;
          index <= '0;
        end
        UPDATE: begin
          W_new[base +: n]   <= w_sub.val;
          err_out[base +: n] <= err_m.val;
          ovf                <= ovf | prod_m.sat | w_sub.sat | err_m.sat;
          if (!last) index <= index + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: operand latches carry no reset; they are always loaded before they are read.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      x_l     <= X;
      w_l     <= W;
      delta_l <= delta;
    end
  end

endmodule

// File: tb/tb_s1neuron_backprop.sv
// Directed self-checking bench for s1neuron_backprop (M=8, Q12.20, LR=2^-8).
module tb_s1neuron_backprop;
  localparam int M = 8;
  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [M*N-1:0] X, W;
  logic [N-1:0]   delta;
  logic           busy, done, ovf;
  logic [M*N-1:0] W_new, err_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  s1neuron_backprop #(
    .M(M), .n(N), .intbits(12), .fracbits(20), .LR(32'h0000_1000)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .W(W), .delta(delta),
    .busy(busy), .done(done), .W_new(W_new), .err_out(err_out), .ovf(ovf)
  );

  function automatic logic [M*N-1:0] fill(input logic [N-1:0] v);
    logic [M*N-1:0] r;
    for (int i = 0; i < M; i++) r[i*N +: N] = v;
    return r;
  endfunction

  // Start one job, scramble inputs afterwards, wait (bounded) for done.
  task automatic run_job(input logic [M*N-1:0] x, input logic [M*N-1:0] w,
                         input logic [N-1:0] d, output int done_cyc, output logic busy_ok);
    int cyc;
    @(negedge clk);
    X = x; W = w; delta = d; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; X = ~x; W = ~w; delta = ~d;
    cyc = 1; done_cyc = -1; busy_ok = 1'b1;
    while (cyc < 40 && done_cyc < 0) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) done_cyc = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; X = '0; W = '0; delta = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if ({busy, done, ovf} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, ovf}); end
    total++; if (W_new !== '0) begin bad++; $display("FAIL reset_wnew: got %h want 0", W_new); end
    total++; if (err_out !== '0) begin bad++; $display("FAIL reset_err: got %h want 0", err_out); end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int dc; logic bok;
    run_job(fill(32'h0020_0000), fill(32'h0010_0000), 32'h0010_0000, dc, bok);
    total++; if (dc !== 10) begin bad++; $display("FAIL nom_done_cycle: got %0d want 10", dc); end
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL nom_busy: got %b want 1", bok); end
    for (int i = 0; i < M; i++) begin
      total++; if (W_new[i*N +: N] !== 32'h000F_E000) begin bad++; $display("FAIL nom_wnew[%0d]: got %h want 000fe000", i, W_new[i*N +: N]); end
      total++; if (err_out[i*N +: N] !== 32'h0010_0000) begin bad++; $display("FAIL nom_err[%0d]: got %h want 00100000", i, err_out[i*N +: N]); end
    end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL nom_ovf: got %b want 0", ovf); end
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL nom_after_done: got %b want 00", {busy, done}); end
  endtask

  task automatic test_sub_sat();
    int dc; logic bok; logic [M*N-1:0] w;
    w = fill(32'h0010_0000);
    w[3*N +: N] = 32'h8000_0000;
    run_job(fill(32'h0010_0000), w, 32'h0010_0000, dc, bok);
    total++; if (dc !== 10) begin bad++; $display("FAIL sub_done_cycle: got %0d want 10", dc); end
    for (int i = 0; i < M; i++) begin
      total++;
      if (W_new[i*N +: N] !== ((i == 3) ? 32'h8000_0000 : 32'h000F_F000)) begin
        bad++; $display("FAIL sub_wnew[%0d]: got %h", i, W_new[i*N +: N]);
      end
      total++;
      if (err_out[i*N +: N] !== ((i == 3) ? 32'h8000_0000 : 32'h0010_0000)) begin
        bad++; $display("FAIL sub_err[%0d]: got %h", i, err_out[i*N +: N]);
      end
    end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL sub_ovf: got %b want 1", ovf); end
    repeat (3) @(negedge clk);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL sub_ovf_hold: got %b want 1", ovf); end
    total++; if (W_new[3*N +: N] !== 32'h8000_0000) begin bad++; $display("FAIL sub_hold: got %h want 80000000", W_new[3*N +: N]); end
  endtask

  task automatic test_truncation();
    int dc; logic bok; logic [M*N-1:0] x;
    x = '0;
    x[0 +: N] = 32'h0000_0001;
    run_job(x, '0, 32'hFFF0_0000, dc, bok);
    total++; if (dc !== 10) begin bad++; $display("FAIL trn_done_cycle: got %0d want 10", dc); end
    total++; if (W_new[0 +: N] !== 32'h0000_0001) begin bad++; $display("FAIL trn_wnew0: got %h want 00000001", W_new[0 +: N]); end
    total++; if (W_new[M*N-1:N] !== '0) begin bad++; $display("FAIL trn_wnew_rest: got %h want 0", W_new[M*N-1:N]); end
    total++; if (err_out !== '0) begin bad++; $display("FAIL trn_err: got %h want 0", err_out); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL trn_ovf_cleared: got %b want 0", ovf); end
  endtask

  task automatic test_mul_sat();
    int dc; logic bok; logic [M*N-1:0] w;
    w = '0;
    w[5*N +: N] = 32'h0040_0000;
    run_job('0, w, 32'h7FF0_0000, dc, bok);
    total++; if (dc !== 10) begin bad++; $display("FAIL mul_done_cycle: got %0d want 10", dc); end
    for (int i = 0; i < M; i++) begin
      total++;
      if (W_new[i*N +: N] !== ((i == 5) ? 32'h0040_0000 : 32'h0)) begin
        bad++; $display("FAIL mul_wnew[%0d]: got %h", i, W_new[i*N +: N]);
      end
      total++;
      if (err_out[i*N +: N] !== ((i == 5) ? 32'h7FFF_FFFF : 32'h0)) begin
        bad++; $display("FAIL mul_err[%0d]: got %h", i, err_out[i*N +: N]);
      end
    end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL mul_ovf: got %b want 1", ovf); end
  endtask

  // start held for 12 edges: jobs accepted at edge 0 (X=1.0) and edge 11 (X=12.0).
  task automatic test_back_to_back();
    int cyc; logic exp_done, exp_busy; logic [N-1:0] v;
    @(negedge clk);
    W = fill(32'h0010_0000); delta = 32'h0010_0000; X = fill(32'h0010_0000); start = 1'b1;
    for (int c = 0; c < 26; c++) begin
      @(posedge clk);
      @(negedge clk);
      cyc = c + 1;
      if (cyc < 12) begin
        v = 32'(cyc + 1) << 20;
        X = fill(v);
      end
      if (cyc == 12) start = 1'b0;
      exp_done = (cyc == 10) || (cyc == 21);
      exp_busy = (cyc <= 10) || (cyc >= 12 && cyc <= 21);
      total++; if (done !== exp_done) begin bad++; $display("FAIL b2b_done@%0d: got %b want %b", cyc, done, exp_done); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL b2b_busy@%0d: got %b want %b", cyc, busy, exp_busy); end
      if (cyc == 10) begin
        total++; if (W_new !== fill(32'h000F_F000)) begin bad++; $display("FAIL b2b_job1: got %h want all 000ff000", W_new); end
      end
    end
    total++; if (W_new !== fill(32'h000F_4000)) begin bad++; $display("FAIL b2b_job2: got %h want all 000f4000", W_new); end
  endtask

  task automatic test_reset_mid_job();
    int dc; logic bok;
    @(negedge clk);
    X = '0; W = fill(32'h0040_0000); delta = 32'h7FF0_0000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL mid_ovf: got %b want 1", ovf); end
    total++; if (W_new[1*N +: N] !== 32'h0040_0000) begin bad++; $display("FAIL mid_written: got %h want 00400000", W_new[1*N +: N]); end
    total++; if (W_new[2*N +: N] !== 32'h000F_4000) begin bad++; $display("FAIL mid_kept_w: got %h want 000f4000", W_new[2*N +: N]); end
    total++; if (err_out[2*N +: N] !== 32'h0010_0000) begin bad++; $display("FAIL mid_kept_err: got %h want 00100000", err_out[2*N +: N]); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if ({busy, done, ovf} !== 3'b000) begin bad++; $display("FAIL mid_rst_flags: got %b want 000", {busy, done, ovf}); end
    total++; if (W_new !== '0) begin bad++; $display("FAIL mid_rst_wnew: got %h want 0", W_new); end
    total++; if (err_out !== '0) begin bad++; $display("FAIL mid_rst_err: got %h want 0", err_out); end
    run_job(fill(32'h0020_0000), fill(32'h0010_0000), 32'h0010_0000, dc, bok);
    total++; if (dc !== 10) begin bad++; $display("FAIL mid_rerun_cycle: got %0d want 10", dc); end
    total++; if (W_new !== fill(32'h000F_E000)) begin bad++; $display("FAIL mid_rerun_wnew: got %h", W_new); end
    total++; if (err_out !== fill(32'h0010_0000)) begin bad++; $display("FAIL mid_rerun_err: got %h", err_out); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL mid_rerun_ovf: got %b want 0", ovf); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_sub_sat();
    test_truncation();
    test_mul_sat();
    test_back_to_back();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
